// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter that shares one async-read / sync-write memory between
// NUM_REQ requesters. Reads and writes are arbitrated independently, so one
// read and one write can complete in the same cycle. Grants are combinational;
// read data comes back registered one cycle after the grant.
module memory_access_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DEPTH    = 256,
  parameter int BIT_SIZE = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*$clog2(DEPTH)-1:0]    req_addr,
  input  logic [NUM_REQ*BIT_SIZE-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [BIT_SIZE-1:0]                 rsp_data,
  output logic                                mem_write_enable,
  output logic [$clog2(DEPTH)-1:0]            mem_write_addr,
  output logic [BIT_SIZE-1:0]                 mem_data_in,
  output logic [$clog2(DEPTH)-1:0]            mem_read_addr,
  input  logic [BIT_SIZE-1:0]                 mem_data_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [NUM_REQ-1:0] wr_cand;
  logic [NUM_REQ-1:0] rd_cand;
  logic [PW:0]        wr_pick;
  logic [PW:0]        rd_pick;
  logic [NUM_REQ-1:0] wr_gnt;
  logic [NUM_REQ-1:0] rd_gnt;

  // Returns {found, winner}: first set bit of cand scanning upward from ptr,
  // wrapping at NUM_REQ. Scanning the offsets high-to-low lets the smallest
  // offset overwrite the result last.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                          input logic [PW-1:0]      ptr);
    logic [PW:0]   res;
    logic [PW-1:0] sel;
    int            idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PW'(idx);
      if (cand[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  // Pointer advance past the winner; wraps explicitly so a non-power-of-two
  // NUM_REQ never produces an out-of-range pointer.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] win);
    return (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  endfunction

  // Candidate selection, grant vectors and memory-port muxing. Reset masks all
  // candidates so nothing is granted or driven while rst is high.
  always_comb begin
    wr_cand          = req_valid &  req_write & {NUM_REQ{~rst}};
    rd_cand          = req_valid & ~req_write & {NUM_REQ{~rst}};
    wr_pick          = rr_pick(wr_cand, wr_ptr);
    rd_pick          = rr_pick(rd_cand, rd_ptr);
    wr_gnt           = '0;
    rd_gnt           = '0;
    mem_write_enable = wr_pick[PW];
    mem_write_addr   = '0;
    mem_data_in      = '0;
    mem_read_addr    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_gnt[i] = wr_pick[PW] && (wr_pick[PW-1:0] == PW'(i));
      rd_gnt[i] = rd_pick[PW] && (rd_pick[PW-1:0] == PW'(i));
      if (wr_gnt[i]) begin
        mem_write_addr = req_addr[i*AW +: AW];
        mem_data_in    = req_wdata[i*BIT_SIZE +: BIT_SIZE];
      end
      if (rd_gnt[i]) mem_read_addr = req_addr[i*AW +: AW];
    end
    req_ready = wr_gnt | rd_gnt;
  end

  // Pointer update and registered read response; a reset edge drops any
  // response that would otherwise have been captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (wr_pick[PW]) wr_ptr <= next_ptr(wr_pick[PW-1:0]);
      if (rd_pick[PW]) begin
        rd_ptr   <= next_ptr(rd_pick[PW-1:0]);
        rsp_data <= mem_data_out;
      end
      rsp_valid <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter with a behavioural async-read /
// sync-write memory attached and a shadow copy for expected read data.
module tb_memory_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_write_enable;
  logic [AW-1:0]   mem_write_addr;
  logic [DW-1:0]   mem_data_in;
  logic [AW-1:0]   mem_read_addr;
  logic [DW-1:0]   mem_data_out;

  memory_access_arbiter #(.NUM_REQ(N), .DEPTH(256), .BIT_SIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_data_in(mem_data_in), .mem_read_addr(mem_read_addr),
    .mem_data_out(mem_data_out)
  );

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] smem [256];

  assign mem_data_out = mem[mem_read_addr];
  always @(posedge clk) if (mem_write_enable) mem[mem_write_addr] <= mem_data_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] v; logic [DW-1:0] d; } rsp_t;
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // One cycle: called at posedge+1, drives inputs, checks the combinational
  // grant/memory ports mid-cycle, then checks the registered response after
  // the edge against the scoreboard.
  task automatic step(input string tag, input logic r, input logic [N-1:0] v,
                      input logic [N-1:0] w, input logic [N-1:0] exp_ready);
    logic [N-1:0] wwin, rwin;
    logic [DW-1:0] rdat;
    rsp_t e, got;
    int wi, ri;
    rst       = r;
    req_valid = v;
    req_write = w;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a_addr[i];
      req_wdata[i*DW +: DW] = a_wdata[i];
    end
    #2;
    wwin = exp_ready & v & w;
    rwin = exp_ready & v & ~w;
    wi   = idx_of(wwin);
    ri   = idx_of(rwin);
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
    chk({tag, ".we"}, 32'(mem_write_enable), 32'(|wwin));
    chk({tag, ".waddr"}, 32'(mem_write_addr), (|wwin) ? 32'(a_addr[wi]) : 32'd0);
    chk({tag, ".wdata"}, 32'(mem_data_in), (|wwin) ? 32'(a_wdata[wi]) : 32'd0);
    chk({tag, ".raddr"}, 32'(mem_read_addr), (|rwin) ? 32'(a_addr[ri]) : 32'd0);
    rdat = (|rwin) ? smem[a_addr[ri]] : last_data;
    if (r) rdat = '0;
    e.v = r ? '0 : rwin;
    e.d = rdat;
    rsp_q.push_back(e);
    last_data = rdat;
    if (!r && (|wwin)) smem[a_addr[wi]] = a_wdata[wi];
    @(posedge clk);
    #1;
    got.v = rsp_valid;
    got.d = rsp_data;
    if (rsp_q.size() == 0) begin
      chk({tag, ".rspq"}, 32'd0, 32'd1);
    end else begin
      e = rsp_q.pop_front();
      chk({tag, ".rsp_valid"}, 32'(got.v), 32'(e.v));
      chk({tag, ".rsp_data"}, 32'(got.d), 32'(e.d));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'(i) ^ 16'hA5A5;
      smem[i] = 16'(i) ^ 16'hA5A5;
    end
    last_data = '0;
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = 8'(i);
      a_wdata[i] = 16'(100 + i);
    end
    @(posedge clk);
    #1;

    // reset with all requesters reading
    step("rst0", 1'b1, 4'b1111, 4'b0000, 4'b0000);
    step("rst1", 1'b1, 4'b1111, 4'b0000, 4'b0000);
    step("rel",  1'b0, 4'b1111, 4'b0000, 4'b0001);
    step("idle", 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // write round robin, addr i = 100+i
    step("wr0", 1'b0, 4'b1111, 4'b1111, 4'b0001);
    step("wr1", 1'b0, 4'b1111, 4'b1111, 4'b0010);
    step("wr2", 1'b0, 4'b1111, 4'b1111, 4'b0100);
    step("wr3", 1'b0, 4'b1111, 4'b1111, 4'b1000);
    step("wr4", 1'b0, 4'b1111, 4'b1111, 4'b0001);

    // realign pointers, then read round robin
    step("rstb", 1'b1, 4'b0000, 4'b0000, 4'b0000);
    step("rd0", 1'b0, 4'b1111, 4'b0000, 4'b0001);
    step("rd1", 1'b0, 4'b1111, 4'b0000, 4'b0010);
    step("rd2", 1'b0, 4'b1111, 4'b0000, 4'b0100);
    step("rd3", 1'b0, 4'b1111, 4'b0000, 4'b1000);
    step("rd_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    chk("rd_hold_data", 32'(rsp_data), 32'd103);

    // concurrent read/write to the same address
    a_addr[0] = 8'd5; a_wdata[0] = 16'd7;
    step("pre5", 1'b0, 4'b0001, 4'b0001, 4'b0001);
    a_addr[1] = 8'd5; a_wdata[1] = 16'd42;
    a_addr[2] = 8'd5;
    step("rw5",  1'b0, 4'b0110, 4'b0010, 4'b0110);
    step("re5",  1'b0, 4'b0100, 4'b0000, 4'b0100);
    chk("re5_new", 32'(rsp_data), 32'd42);

    // fairness: req3 continuous, req0 re-requests every 3 cycles (rd_ptr=3)
    a_addr[0] = 8'd0; a_addr[3] = 8'd3;
    step("fa0", 1'b0, 4'b1001, 4'b0000, 4'b1000);
    step("fa1", 1'b0, 4'b1001, 4'b0000, 4'b0001);
    step("fa2", 1'b0, 4'b1000, 4'b0000, 4'b1000);
    step("fa3", 1'b0, 4'b1000, 4'b0000, 4'b1000);
    step("fa4", 1'b0, 4'b1001, 4'b0000, 4'b0001);
    step("fa5", 1'b0, 4'b1000, 4'b0000, 4'b1000);
    step("fa6", 1'b0, 4'b1000, 4'b0000, 4'b1000);
    step("fa7", 1'b0, 4'b1001, 4'b0000, 4'b0001);

    // reset mid-operation with three pending reads
    a_addr[1] = 8'd1; a_addr[2] = 8'd2;
    step("mr_a", 1'b0, 4'b0111, 4'b0000, 4'b0010);
    step("mr_b", 1'b1, 4'b0111, 4'b0000, 4'b0000);
    step("mr_c", 1'b0, 4'b0111, 4'b0000, 4'b0001);
    step("mr_d", 1'b0, 4'b0110, 4'b0000, 4'b0010);
    step("mr_e", 1'b0, 4'b0100, 4'b0000, 4'b0100);
    step("mr_f", 1'b0, 4'b0000, 4'b0000, 4'b0000);

    chk("mem0", 32'(mem[0]), 32'd100);
    chk("mem3", 32'(mem[3]), 32'd103);
    chk("mem5", 32'(mem[5]), 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
